reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Staged reset controller for the WSPRBerry FPGA. It holds the core, DDS/NCO and WSPR symbol-generator reset domains asserted until the PLL lock is stable and a power-on delay has elapsed. It then releases the domains one at a time with a fixed gap between each. It re-asserts all domains on PLL lock loss or on a soft-reset request, and counts lock-loss faults. It sits at the top level between the PLL and all downstream logic.

## Interface
- CNT_W, 24: width of the shared delay counter.
- LOCK_FILTER, 8: consecutive synchronised-lock cycles required. Legal range 1..2^CNT_W-1.
- POR_DELAY, 24'h0F0000: cycles from filtered lock to `rst_core` release. Legal range 1..2^CNT_W-1.
- STAGE_GAP, 4096: cycles between successive domain releases. Legal range 1..2^CNT_W-1.

- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- pll_locked, in, 1: PLL lock. Asynchronous to `clock`.
- soft_reset_req, in, 1: single-cycle synchronous pulse that requests a full re-sequence.
- rst_core, out, 1: active-high reset for the core domain.
- rst_dds, out, 1: active-high reset for the DDS/NCO domain.
- rst_wspr, out, 1: active-high reset for the WSPR symbol-generator domain.
- ready, out, 1: high when all domains are released.
- fault_count, out, 8: number of lock-loss events. Saturates at 255.

## Operation
- `pll_locked` passes through a 2-FF synchroniser to produce `lock_sync`. Both flops reset to 0.
- Asserting `reset` forces the following, asynchronously:
  - state = WAIT_LOCK;
  - `rst_core`, `rst_dds`, `rst_wspr` = 1;
  - `ready` = 0;
  - `fault_count` = 0;
  - filter counter and delay counter = 0.
- WAIT_LOCK:
  - Filter counter +1 on each edge with `lock_sync`=1.
  - Filter counter clears on `lock_sync`=0.
  - On the edge where the filter counter reaches LOCK_FILTER: go to POR, delay counter = 0.
- POR:
  - Delay counter +1 each edge.
  - On the POR_DELAY-th edge in POR: go to STAGE1, `rst_core` := 0, delay counter = 0.
- STAGE1: on the STAGE_GAP-th edge, go to STAGE2 and set `rst_dds` := 0.
- STAGE2: on the STAGE_GAP-th edge, go to RUN and set `rst_wspr` := 0 and `ready` := 1 on the same edge.
- RUN: steady state. All counters idle.
- Lock loss (`lock_sync`=0 in POR, STAGE1, STAGE2 or RUN):
  - Next state is WAIT_LOCK.
  - All three resets go to 1 and `ready` to 0 on that edge.
  - Counters clear.
  - `fault_count` +1, saturating at 255.
- `soft_reset_req`=1 in POR, STAGE1, STAGE2 or RUN: same as lock loss, but `fault_count` does not change.
- `soft_reset_req` in WAIT_LOCK: ignored.
- Lock loss and `soft_reset_req` on the same edge: handled as lock loss, so `fault_count` increments.
- `lock_sync`=0 in WAIT_LOCK: clears the filter counter only. Not counted as a fault.
- Release order is always core, then DDS, then WSPR. Assertion is always simultaneous for all three.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Edges are numbered from the first rising edge after `reset` goes high, which is edge 0.
- With `pll_locked` held high, `lock_sync` is first sampled high by the FSM at edge 2.
- Release times (k = first edge on which `lock_sync` is sampled high):
  - `rst_core` falls at edge k + LOCK_FILTER − 1 + POR_DELAY.
  - `rst_dds` falls STAGE_GAP edges after `rst_core`.
  - `rst_wspr` falls and `ready` rises STAGE_GAP edges after `rst_dds`.
- Re-assertion latency:
  - From `soft_reset_req` sampled: all resets are asserted at that same edge.
  - From a `pll_locked` fall: all resets are asserted 3 edges later (2 synchroniser edges plus the FSM edge).
- Re-sequence after a soft reset at edge s, with lock held high: `rst_core` falls at edge s + LOCK_FILTER + POR_DELAY.

## Structure
- Package `reset_seq_pkg`:
  - state enum: WAIT_LOCK, POR, STAGE1, STAGE2, RUN;
  - FAULT_MAX = 8'hFF.
- Sub-module `sync_2ff`:
  - generic single-bit synchroniser;
  - clock and active-low asynchronous reset;
  - reset value 0.
- One delay counter of width CNT_W is shared by POR, STAGE1 and STAGE2. The filter counter is separate.

## Test plan
All scenarios use LOCK_FILTER=4, POR_DELAY=16, STAGE_GAP=8.
- Normal bring-up, `pll_locked` high from reset release:
  - `rst_core` falls at edge 21;
  - `rst_dds` falls at edge 29;
  - `rst_wspr` falls and `ready` rises at edge 37;
  - `fault_count` = 0.
- Lock glitch: `pll_locked` low for 1 cycle during the filter phase. The filter restarts, `rst_core` release is delayed, and `fault_count` stays 0.
- Lock loss in RUN:
  - `pll_locked` falls at edge N;
  - all resets are 1 and `ready` is 0 at edge N+3;
  - `fault_count` = 1;
  - after lock returns, the full sequence repeats with the same spacing.
- Soft reset in STAGE1 at edge s:
  - all resets are 1 at edge s;
  - `fault_count` unchanged;
  - `rst_core` falls at edge s+20.
- Simultaneous `soft_reset_req` and lock loss: `fault_count` increments by exactly 1.
- Saturation: 300 lock-loss events leave `fault_count` = 255. An asynchronous `reset` mid-STAGE2 drives all outputs to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
// Holds the sequencer state encoding and the saturating fault-counter helper.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      WAIT_LOCK,
      POR,
      STAGE1,
      STAGE2,
      RUN
   } seq_state_t;

   localparam logic [7:0] FAULT_MAX = 8'hFF;

   // Fault counter must stick at its maximum rather than wrap back to zero
   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      return (value == FAULT_MAX) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit.
// Both flops clear to 0 under the active-low asynchronous reset.
module sync_2ff (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: waits for a stable PLL lock and a power-on delay, then
// releases core, DDS and WSPR domains in order; any lock loss or soft request re-asserts all.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned          CNT_W       = 24,
   parameter logic [CNT_W-1:0]     LOCK_FILTER = CNT_W'(8),
   parameter logic [CNT_W-1:0]     POR_DELAY   = CNT_W'(24'h0F0000),
   parameter logic [CNT_W-1:0]     STAGE_GAP   = CNT_W'(4096)
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pll_locked,
   input  logic       soft_reset_req,
   output logic       rst_core,
   output logic       rst_dds,
   output logic       rst_wspr,
   output logic       ready,
   output logic [7:0] fault_count
);

   localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
   localparam logic [CNT_W-1:0] FILTER_LAST = LOCK_FILTER - ONE;
   localparam logic [CNT_W-1:0] POR_LAST    = POR_DELAY - ONE;
   localparam logic [CNT_W-1:0] GAP_LAST    = STAGE_GAP - ONE;

   logic             lock_sync;
   seq_state_t       state, state_nxt;
   logic [CNT_W-1:0] filter_cnt, filter_nxt;
   logic [CNT_W-1:0] delay_cnt, delay_nxt;
   logic             rst_core_nxt, rst_dds_nxt, rst_wspr_nxt, ready_nxt;
   logic [7:0]       fault_nxt;

   sync_2ff u_lock_sync (
      .clock (clock),
      .reset (reset),
      .d     (pll_locked),
      .q     (lock_sync)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= WAIT_LOCK;
         filter_cnt  <= '0;
         delay_cnt   <= '0;
         rst_core    <= 1'b1;
         rst_dds     <= 1'b1;
         rst_wspr    <= 1'b1;
         ready       <= 1'b0;
         fault_count <= 8'd0;
      end else begin
         state       <= state_nxt;
         filter_cnt  <= filter_nxt;
         delay_cnt   <= delay_nxt;
         rst_core    <= rst_core_nxt;
         rst_dds     <= rst_dds_nxt;
         rst_wspr    <= rst_wspr_nxt;
         ready       <= ready_nxt;
         fault_count <= fault_nxt;
      end
   end

   // Outputs are computed as next-state values so every output leaves a flop
   always_comb begin
      state_nxt    = state;
      filter_nxt   = filter_cnt;
      delay_nxt    = delay_cnt;
      rst_core_nxt = rst_core;
      rst_dds_nxt  = rst_dds;
      rst_wspr_nxt = rst_wspr;
      ready_nxt    = ready;
      fault_nxt    = fault_count;

      case (state)
         WAIT_LOCK: begin
            if (!lock_sync) begin
               filter_nxt = '0;
            end else if (filter_cnt == FILTER_LAST) begin
               state_nxt  = POR;
               filter_nxt = '0;
               delay_nxt  = '0;
            end else begin
               filter_nxt = filter_cnt + ONE;
            end
         end
         POR: begin
            if (delay_cnt == POR_LAST) begin
               state_nxt    = STAGE1;
               rst_core_nxt = 1'b0;
               delay_nxt    = '0;
            end else begin
               delay_nxt = delay_cnt + ONE;
            end
         end
         STAGE1: begin
            if (delay_cnt == GAP_LAST) begin
               state_nxt   = STAGE2;
               rst_dds_nxt = 1'b0;
               delay_nxt   = '0;
            end else begin
               delay_nxt = delay_cnt + ONE;
            end
         end
         STAGE2: begin
            if (delay_cnt == GAP_LAST) begin
               state_nxt    = RUN;
               rst_wspr_nxt = 1'b0;
               ready_nxt    = 1'b1;
               delay_nxt    = '0;
            end else begin
               delay_nxt = delay_cnt + ONE;
            end
         end
         RUN: begin
         end
         default: begin
            state_nxt = WAIT_LOCK;
         end
      endcase

      // Lock loss outranks a coincident soft request, so it is the one counted
      if ((state != WAIT_LOCK) && (!lock_sync || soft_reset_req)) begin
         state_nxt    = WAIT_LOCK;
         filter_nxt   = '0;
         delay_nxt    = '0;
         rst_core_nxt = 1'b1;
         rst_dds_nxt  = 1'b1;
         rst_wspr_nxt = 1'b1;
         ready_nxt    = 1'b0;
         if (!lock_sync) begin
            fault_nxt = sat_inc(fault_count);
         end
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer with LOCK_FILTER=4, POR_DELAY=16, STAGE_GAP=8.
// Edge numbers count rising edges from the first one after reset release (edge 0).
module tb_reset_sequencer;

   logic       clock = 1'b0;
   logic       reset;
   logic       pll_locked;
   logic       soft_reset_req;
   logic       rst_core;
   logic       rst_dds;
   logic       rst_wspr;
   logic       ready;
   logic [7:0] fault_count;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;
   int curEdge    = -1;

   // Output bit pattern is {rst_core, rst_dds, rst_wspr, ready}
   localparam logic [7:0] OUT_RESET = 8'b0000_1110;
   localparam logic [7:0] OUT_CORE  = 8'b0000_0110;
   localparam logic [7:0] OUT_DDS   = 8'b0000_0010;
   localparam logic [7:0] OUT_RUN   = 8'b0000_0001;

   reset_sequencer #(
      .CNT_W       (24),
      .LOCK_FILTER (24'd4),
      .POR_DELAY   (24'd16),
      .STAGE_GAP   (24'd8)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .pll_locked     (pll_locked),
      .soft_reset_req (soft_reset_req),
      .rst_core       (rst_core),
      .rst_dds        (rst_dds),
      .rst_wspr       (rst_wspr),
      .ready          (ready),
      .fault_count    (fault_count)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] outBits();
      return {4'b0000, rst_core, rst_dds, rst_wspr, ready};
   endfunction

   // Advance to just after the given rising edge
   task automatic applyStimulus(input int target);
      while (curEdge < target) begin
         @(posedge clock);
         curEdge++;
      end
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s at edge %0d: observed=%b expected=%b", tag, curEdge, observed, expected);
      end
   endtask

   initial begin
      reset          = 1'b0;
      pll_locked     = 1'b1;
      soft_reset_req = 1'b0;

      #12;
      checkOutput("reset_outputs", outBits(), OUT_RESET);
      checkOutput("reset_fault", fault_count, 8'd0);
      #10;
      reset = 1'b1;

      // Normal bring-up
      applyStimulus(20);  checkOutput("core_before", outBits(), OUT_RESET);
      applyStimulus(21);  checkOutput("core_release", outBits(), OUT_CORE);
      applyStimulus(28);  checkOutput("dds_before", outBits(), OUT_CORE);
      applyStimulus(29);  checkOutput("dds_release", outBits(), OUT_DDS);
      applyStimulus(36);  checkOutput("wspr_before", outBits(), OUT_DDS);
      applyStimulus(37);  checkOutput("run_reached", outBits(), OUT_RUN);
      checkOutput("bringup_fault", fault_count, 8'd0);

      // Lock loss in RUN, then recovery with identical spacing
      applyStimulus(40);  pll_locked = 1'b0;
      applyStimulus(42);  checkOutput("loss_latency_before", outBits(), OUT_RUN);
      applyStimulus(43);  checkOutput("loss_asserted", outBits(), OUT_RESET);
      checkOutput("loss_fault", fault_count, 8'd1);
      applyStimulus(45);  pll_locked = 1'b1;
      applyStimulus(66);  checkOutput("relock_core_before", outBits(), OUT_RESET);
      applyStimulus(67);  checkOutput("relock_core", outBits(), OUT_CORE);
      applyStimulus(75);  checkOutput("relock_dds", outBits(), OUT_DDS);
      applyStimulus(83);  checkOutput("relock_run", outBits(), OUT_RUN);

      // Soft reset in RUN, then again in STAGE1; a pulse in WAIT_LOCK is ignored
      applyStimulus(89);  soft_reset_req = 1'b1;
      applyStimulus(90);  soft_reset_req = 1'b0;
      checkOutput("soft_run_asserted", outBits(), OUT_RESET);
      applyStimulus(110); checkOutput("soft_run_core", outBits(), OUT_CORE);
      applyStimulus(113); soft_reset_req = 1'b1;
      applyStimulus(114); soft_reset_req = 1'b0;
      checkOutput("soft_stage1_asserted", outBits(), OUT_RESET);
      checkOutput("soft_fault", fault_count, 8'd1);
      applyStimulus(115); soft_reset_req = 1'b1;
      applyStimulus(116); soft_reset_req = 1'b0;
      applyStimulus(133); checkOutput("soft_core_before", outBits(), OUT_RESET);
      applyStimulus(134); checkOutput("soft_core_release", outBits(), OUT_CORE);
      applyStimulus(150); checkOutput("soft_run", outBits(), OUT_RUN);

      // Simultaneous lock loss and soft request
      applyStimulus(157); pll_locked = 1'b0;
      applyStimulus(159); soft_reset_req = 1'b1;
      checkOutput("simul_before", outBits(), OUT_RUN);
      applyStimulus(160); soft_reset_req = 1'b0;
      checkOutput("simul_asserted", outBits(), OUT_RESET);
      checkOutput("simul_fault", fault_count, 8'd2);
      applyStimulus(161); checkOutput("wait_lock_no_fault", fault_count, 8'd2);

      // One-cycle lock glitch during the filter phase restarts the filter
      applyStimulus(162); pll_locked = 1'b1;
      applyStimulus(165); pll_locked = 1'b0;
      applyStimulus(166); pll_locked = 1'b1;
      applyStimulus(184); checkOutput("glitch_no_early_core", outBits(), OUT_RESET);
      applyStimulus(187); checkOutput("glitch_core_before", outBits(), OUT_RESET);
      applyStimulus(188); checkOutput("glitch_core_release", outBits(), OUT_CORE);
      checkOutput("glitch_fault", fault_count, 8'd2);

      // Saturation: 300 lock-loss events starting from a count of 2
      applyStimulus(190); pll_locked = 1'b0;
      applyStimulus(192); checkOutput("sat_first_before", outBits(), OUT_CORE);
      applyStimulus(193); checkOutput("sat_first_fault", fault_count, 8'd3);
      applyStimulus(194);
      for (int i = 0; i < 251; i++) begin
         pll_locked = 1'b1;
         applyStimulus(curEdge + 8);
         pll_locked = 1'b0;
         applyStimulus(curEdge + 4);
      end
      checkOutput("sat_254", fault_count, 8'd254);
      pll_locked = 1'b1;
      applyStimulus(curEdge + 8);
      pll_locked = 1'b0;
      applyStimulus(curEdge + 4);
      checkOutput("sat_255", fault_count, 8'd255);
      for (int i = 0; i < 47; i++) begin
         pll_locked = 1'b1;
         applyStimulus(curEdge + 8);
         pll_locked = 1'b0;
         applyStimulus(curEdge + 4);
      end
      checkOutput("sat_hold", fault_count, 8'd255);

      // Asynchronous reset in the middle of STAGE2
      pll_locked = 1'b1;
      applyStimulus(curEdge + 22); checkOutput("late_core", outBits(), OUT_CORE);
      applyStimulus(curEdge + 8);  checkOutput("late_dds", outBits(), OUT_DDS);
      applyStimulus(curEdge + 3);  checkOutput("stage2_before_reset", outBits(), OUT_DDS);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_reset_outputs", outBits(), OUT_RESET);
      checkOutput("async_reset_fault", fault_count, 8'd0);
      #5;
      reset = 1'b1;
      repeat (3) @(posedge clock);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
